// File: rtl/sys_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// sys_ctrl_gen2
//   Second-generation system controller on the REF_CLK domain. Parses command
//   frames from the synchronised UART RX byte stream, drives register-file
//   read/write and ALU operations, and serialises results (LSB first) into a
//   small output byte queue that is drained towards the UART TX with a
//   TX_BUSY handshake. An inter-byte / ALU timeout aborts stalled frames.
//
//   Frames:  AA,addr,data   write regfile
//            BB,addr        read regfile, queue 1 byte
//            CC,A,B,fun     A->addr0, B->addr1, run ALU, queue NB bytes
//            DD,fun         run ALU on current regs, queue NB bytes
//
// Ports
//   CLK, RST                  REF_CLK, asynchronous active-high reset
//   RX_P_DATA, RX_D_VLD       received byte and its one-cycle strobe
//   address, WrEn, WrData     regfile write port / shared address
//   RdEn, RdData, RdData_Valid regfile read request and response
//   ALU_EN, ALU_FUN, CLK_EN   ALU start strobe, function, clock-gate enable
//   ALU_OUT, ALU_OUT_VLD      ALU result and its valid
//   TX_P_DATA, TX_D_VLD       byte to UART TX and its one-cycle strobe
//   TX_BUSY                   synchronised UART TX busy
//   clk_div_en                TX clock divider enable (1 out of reset)
//   CMD_ERR                   one-cycle pulse: bad command or timeout
// -----------------------------------------------------------------------------
module sys_ctrl_gen2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]    address,
    output logic                     WrEn,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     RdEn,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    output logic                     ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     CLK_EN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_BUSY,
    output logic                     clk_div_en,
    output logic                     CMD_ERR
);

    localparam int NB    = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH) + 1;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hDD);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN_S, ALU_RUN, ALU_WAIT, PUSH_RES, PUSH_RD
    } state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;

    state_t                     state, state_nx;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_nx;
    logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_nx;
    logic                       wr_en_q, wr_en_nx, rd_en_q, rd_en_nx;
    logic                       alu_en_q, alu_en_nx, clk_en_q, clk_en_nx;
    logic                       cmd_err_q, cmd_err_nx;
    logic [ALU_FUN_WIDTH-1:0]   alu_fun_q, alu_fun_nx;
    logic [ALU_OUT_WIDTH-1:0]   alu_res_q, alu_res_nx;
    logic [DATA_WIDTH-1:0]      rd_byte_q, rd_byte_nx;
    logic [IDX_W-1:0]           byte_idx_q, byte_idx_nx;
    logic [TMO_W-1:0]           tmo_cnt, tmo_cnt_nx;
    logic                       timed;

    // Output byte queue
    logic [DATA_WIDTH-1:0]      mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic                       full, empty, push, pop, can_push;
    logic [DATA_WIDTH-1:0]      push_data, head;

    tx_state_t                  tx_state, tx_nx;
    logic                       tx_vld_q, tx_vld_nx;
    logic [DATA_WIDTH-1:0]      tx_data_q, tx_data_nx;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {(PTR_W-1){1'b0}}});
    assign head     = mem[rd_ptr[PTR_W-2:0]];
    // A pop in the same cycle frees the slot being written, so a full queue
    // still accepts a push.
    assign can_push = !full || pop;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        addr_nx     = addr_q;
        wr_data_nx  = wr_data_q;
        wr_en_nx    = 1'b0;
        rd_en_nx    = 1'b0;
        alu_en_nx   = 1'b0;
        alu_fun_nx  = alu_fun_q;
        clk_en_nx   = clk_en_q;
        cmd_err_nx  = 1'b0;
        alu_res_nx  = alu_res_q;
        rd_byte_nx  = rd_byte_q;
        byte_idx_nx = byte_idx_q;
        push        = 1'b0;
        push_data   = rd_byte_q;
        timed       = 1'b0;

        case (state)
            IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    CMD_WR:  state_nx = WR_ADDR;
                    CMD_RD:  state_nx = RD_ADDR;
                    CMD_OPS: state_nx = OP_A;
                    CMD_ALU: state_nx = ALU_FUN_S;
                    default: cmd_err_nx = 1'b1;
                endcase
            end
            WR_ADDR: begin
                timed = 1'b1;
                if (RX_D_VLD) begin
                    addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nx = WR_DATA;
                end
            end
            WR_DATA: begin
                timed = 1'b1;
                if (RX_D_VLD) begin
                    wr_data_nx = RX_P_DATA;
                    wr_en_nx   = 1'b1;
                    state_nx   = IDLE;
                end
            end
            RD_ADDR: begin
                timed = 1'b1;
                if (RX_D_VLD) begin
                    addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_nx = 1'b1;
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: if (RdData_Valid) begin
                rd_byte_nx = RdData;
                state_nx   = PUSH_RD;
            end
            PUSH_RD: if (can_push) begin
                push      = 1'b1;
                push_data = rd_byte_q;
                state_nx  = IDLE;
            end
            OP_A: begin
                timed = 1'b1;
                if (RX_D_VLD) begin
                    addr_nx    = '0;
                    wr_data_nx = RX_P_DATA;
                    wr_en_nx   = 1'b1;
                    state_nx   = OP_B;
                end
            end
            OP_B: begin
                timed = 1'b1;
                if (RX_D_VLD) begin
                    addr_nx    = ADDR_WIDTH'(1);
                    wr_data_nx = RX_P_DATA;
                    wr_en_nx   = 1'b1;
                    state_nx   = ALU_FUN_S;
                end
            end
            ALU_FUN_S: begin
                timed = 1'b1;
                if (RX_D_VLD) begin
                    alu_fun_nx = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    alu_en_nx  = 1'b1;
                    clk_en_nx  = 1'b1;
                    state_nx   = ALU_RUN;
                end
            end
            ALU_RUN: state_nx = ALU_WAIT;
            ALU_WAIT: begin
                timed = 1'b1;
                if (ALU_OUT_VLD) begin
                    alu_res_nx  = ALU_OUT;
                    clk_en_nx   = 1'b0;
                    byte_idx_nx = '0;
                    state_nx    = PUSH_RES;
                end
            end
            PUSH_RES: if (can_push) begin
                // Result is shifted down so the next byte is always at the bottom.
                push       = 1'b1;
                push_data  = alu_res_q[DATA_WIDTH-1:0];
                alu_res_nx = alu_res_q >> DATA_WIDTH;
                if (byte_idx_q == IDX_W'(NB - 1)) state_nx = IDLE;
                else byte_idx_nx = byte_idx_q + IDX_W'(1);
            end
            default: state_nx = IDLE;
        endcase

        // Timeout only fires while still waiting; a byte on the last cycle wins.
        if (timed && (state_nx == state) && (tmo_cnt == TMO_LAST)) begin
            state_nx   = IDLE;
            cmd_err_nx = 1'b1;
            clk_en_nx  = 1'b0;
        end

        tmo_cnt_nx = (!timed || (state_nx != state)) ? '0 : tmo_cnt + TMO_W'(1);
    end

    always_comb begin
        tx_nx      = tx_state;
        tx_vld_nx  = 1'b0;
        tx_data_nx = tx_data_q;
        pop        = 1'b0;
        case (tx_state)
            TX_IDLE: if (!empty && !TX_BUSY) begin
                pop        = 1'b1;
                tx_vld_nx  = 1'b1;
                tx_data_nx = head;
                tx_nx      = TX_WAIT_HI;
            end
            TX_WAIT_HI: if (TX_BUSY)  tx_nx = TX_WAIT_LO;
            TX_WAIT_LO: if (!TX_BUSY) tx_nx = TX_IDLE;
            default:    tx_nx = TX_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            alu_fun_q  <= '0;
            clk_en_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            alu_res_q  <= '0;
            rd_byte_q  <= '0;
            byte_idx_q <= '0;
            tmo_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tx_state   <= TX_IDLE;
            tx_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            clk_div_en <= 1'b0;
        end else begin
            state      <= state_nx;
            addr_q     <= addr_nx;
            wr_data_q  <= wr_data_nx;
            wr_en_q    <= wr_en_nx;
            rd_en_q    <= rd_en_nx;
            alu_en_q   <= alu_en_nx;
            alu_fun_q  <= alu_fun_nx;
            clk_en_q   <= clk_en_nx;
            cmd_err_q  <= cmd_err_nx;
            alu_res_q  <= alu_res_nx;
            rd_byte_q  <= rd_byte_nx;
            byte_idx_q <= byte_idx_nx;
            tmo_cnt    <= tmo_cnt_nx;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            tx_state   <= tx_nx;
            tx_vld_q   <= tx_vld_nx;
            tx_data_q  <= tx_data_nx;
            clk_div_en <= 1'b1;
        end
    end

    // NOTE: queue storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost area.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[PTR_W-2:0]] <= push_data;
    end

    assign address   = addr_q;
    assign WrEn      = wr_en_q;
    assign WrData    = wr_data_q;
    assign RdEn      = rd_en_q;
    assign ALU_EN    = alu_en_q;
    assign ALU_FUN   = alu_fun_q;
    assign CLK_EN    = clk_en_q;
    assign CMD_ERR   = cmd_err_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl_gen2
//   Self-checking bench for sys_ctrl_gen2. Peripheral models (regfile, ALU,
//   UART TX) run on the falling edge; expected TX bytes come from a frame-level
//   model of the register contents and the ALU function table.
// -----------------------------------------------------------------------------
module tb_sys_ctrl_gen2;

    localparam int TMO = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [3:0]  address;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, clk_div_en, CMD_ERR;
    logic [7:0]  WrData, TX_P_DATA;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_BUSY = 1'b0;

    sys_ctrl_gen2 #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .ALU_OUT_WIDTH(16),
        .TX_FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .address(address), .WrEn(WrEn), .WrData(WrData), .RdEn(RdEn),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .clk_div_en(clk_div_en), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // ALU function table of the attached ALU peripheral.
    function automatic logic [15:0] alu_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;

    logic [7:0] periph_regs [16];   // what the attached regfile holds
    logic [7:0] exp_regs [16];      // what the frames sent should have produced
    wr_t        wr_q [$];
    logic [7:0] exp_q [$];
    int  n_rd = 0, n_alu_en = 0, n_err = 0, n_tx = 0, cyc = 0, err_cyc = 0;
    int  alu_cnt = 0, busy_cnt = 0;
    bit  rd_pend = 0, alu_hang = 0, hold_busy = 0;
    logic [3:0] rd_addr_l = '0, alu_fun_l = '0;

    initial for (int i = 0; i < 16; i++) begin
        periph_regs[i] = '0;
        exp_regs[i]    = '0;
    end

    always @(posedge CLK) cyc++;

    // Peripheral models and output monitors.
    always @(negedge CLK) begin
        if (RST) begin
            rd_pend = 0; RdData_Valid = 0; ALU_OUT_VLD = 0;
            alu_cnt = 0; busy_cnt = 0; TX_BUSY = hold_busy;
        end else begin
            RdData_Valid = 0;
            if (rd_pend) begin
                RdData_Valid = 1; RdData = periph_regs[rd_addr_l]; rd_pend = 0;
            end
            if (RdEn) begin rd_pend = 1; rd_addr_l = address; n_rd++; end
            if (WrEn) begin periph_regs[address] = WrData; wr_q.push_back({address, WrData}); end

            ALU_OUT_VLD = 0;
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    ALU_OUT_VLD = 1;
                    ALU_OUT = alu_op(alu_fun_l, periph_regs[0], periph_regs[1]);
                end
            end
            if (ALU_EN) begin
                n_alu_en++;
                check("clk_en_with_alu_en", 32'(CLK_EN), 1);
                alu_fun_l = ALU_FUN;
                if (!alu_hang) alu_cnt = $urandom_range(1, 4);
            end

            if (CMD_ERR) begin n_err++; err_cyc = cyc; end

            if (TX_D_VLD) begin
                n_tx++;
                check("tx_byte_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_byte", 32'(TX_P_DATA), 32'(exp_q.pop_front()));
                busy_cnt = 3;
            end else if (busy_cnt > 0) busy_cnt--;
            TX_BUSY = hold_busy || (busy_cnt != 0);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic wait_drain(input string tag);
        int i = 0;
        while (exp_q.size() != 0 && i < 300) begin @(negedge CLK); i++; end
        check(tag, 32'(exp_q.size()), 0);
        wait_cycles(6);
    endtask

    task automatic wait_alu(input int a0, input string tag);
        int i = 0;
        while (n_alu_en == a0 && i < 60) begin @(negedge CLK); i++; end
        check(tag, 32'(n_alu_en - a0), 1);
    endtask

    task automatic frame_wr(input logic [7:0] ab, input logic [7:0] d);
        wr_q.delete();
        exp_regs[ab[3:0]] = d;
        send_byte(8'hAA); send_byte(ab); send_byte(d);
        wait_cycles(4);
        check("wr_count", 32'(wr_q.size()), 1);
        if (wr_q.size() >= 1) begin
            check("wr_addr", 32'(wr_q[0].a), 32'(ab[3:0]));
            check("wr_data", 32'(wr_q[0].d), 32'(d));
        end
    endtask

    task automatic frame_rd(input logic [7:0] ab);
        int r0 = n_rd;
        exp_q.push_back(exp_regs[ab[3:0]]);
        send_byte(8'hBB); send_byte(ab);
        wait_drain("rd_drain");
        check("rd_strobes", 32'(n_rd - r0), 1);
    endtask

    task automatic push_result(input logic [3:0] f);
        logic [15:0] r;
        r = alu_op(f, exp_regs[0], exp_regs[1]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endtask

    task automatic frame_cc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fb);
        wr_q.delete();
        exp_regs[0] = a; exp_regs[1] = b;
        push_result(fb[3:0]);
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(fb);
        wait_drain("cc_drain");
        check("cc_wr_count", 32'(wr_q.size()), 2);
        if (wr_q.size() == 2) begin
            check("cc_wr0", 32'(wr_q[0]), 32'({4'd0, a}));
            check("cc_wr1", 32'(wr_q[1]), 32'({4'd1, b}));
        end
        check("cc_alu_fun", 32'(ALU_FUN), 32'(fb[3:0]));
        check("cc_clk_en_low", 32'(CLK_EN), 0);
    endtask

    task automatic frame_dd(input logic [7:0] fb);
        push_result(fb[3:0]);
        send_byte(8'hDD); send_byte(fb);
        wait_drain("dd_drain");
        check("dd_alu_fun", 32'(ALU_FUN), 32'(fb[3:0]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_address"},    32'(address), 0);
        check({tag, "_wren"},       32'(WrEn), 0);
        check({tag, "_wrdata"},     32'(WrData), 0);
        check({tag, "_rden"},       32'(RdEn), 0);
        check({tag, "_alu_en"},     32'(ALU_EN), 0);
        check({tag, "_alu_fun"},    32'(ALU_FUN), 0);
        check({tag, "_clk_en"},     32'(CLK_EN), 0);
        check({tag, "_tx_data"},    32'(TX_P_DATA), 0);
        check({tag, "_tx_vld"},     32'(TX_D_VLD), 0);
        check({tag, "_clk_div_en"}, 32'(clk_div_en), 0);
        check({tag, "_cmd_err"},    32'(CMD_ERR), 0);
    endtask

    initial begin
        int e0, t0, a0, c0, i;
        logic [7:0] b1, b2, b3;

        // Reset state
        wait_cycles(3);
        check_outputs_zero("reset");
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK);
        check("clk_div_en_after_reset", 32'(clk_div_en), 1);

        // Plain write: no TX and no error
        e0 = n_err; t0 = n_tx;
        frame_wr(8'h05, 8'h3C);
        check("wr_no_tx", 32'(n_tx - t0), 0);
        check("wr_no_err", 32'(n_err - e0), 0);

        // Read back
        frame_rd(8'h05);

        // Operand load + ADD
        frame_cc(8'h12, 8'h34, 8'h00);

        // Unknown command byte
        e0 = n_err;
        send_byte(8'h77);
        wait_cycles(3);
        check("bad_cmd_err_pulse", 32'(n_err - e0), 1);

        // Inter-byte timeout after AA,05
        e0 = n_err; wr_q.delete();
        @(negedge CLK); RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1;
        @(negedge CLK); RX_P_DATA = 8'h05; c0 = cyc;
        @(negedge CLK); RX_D_VLD = 1'b0;
        i = 0;
        while (n_err == e0 && i < TMO + 50) begin @(negedge CLK); i++; end
        wait_cycles(2);
        check("timeout_err_count", 32'(n_err - e0), 1);
        check("timeout_latency", 32'(err_cyc - c0), 32'(TMO + 1));
        check("timeout_no_write", 32'(wr_q.size()), 0);
        frame_rd(8'h05);

        // Back-pressure: queue fills with TX held busy, third result stalls
        hold_busy = 1; wait_cycles(2);
        t0 = n_tx;
        for (int k = 0; k < 3; k++) begin
            b1 = 8'($urandom_range(0, 5));
            push_result(b1[3:0]);
            a0 = n_alu_en;
            send_byte(8'hDD); send_byte(b1);
            wait_alu(a0, "stall_alu_start");
            wait_cycles(12);
        end
        check("stall_no_tx", 32'(n_tx - t0), 0);
        e0 = n_err;
        send_byte(8'h77);
        wait_cycles(4);
        check("stall_ignores_rx", 32'(n_err - e0), 0);
        hold_busy = 0;
        wait_cycles(40);
        for (int k = 0; k < 2; k++) begin
            b1 = 8'($urandom_range(0, 5));
            push_result(b1[3:0]);
            a0 = n_alu_en;
            send_byte(8'hDD); send_byte(b1);
            wait_alu(a0, "stall_alu_start_late");
            wait_cycles(12);
        end
        wait_drain("stall_drain");
        check("stall_tx_total", 32'(n_tx - t0), 10);

        // Randomised frames
        for (int k = 0; k < 24; k++) begin
            b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            case ($urandom_range(0, 3))
                0: frame_wr(b1, b2);
                1: frame_rd(b1);
                2: frame_cc(b1, b2, b3);
                default: frame_dd(b3);
            endcase
        end

        // Reset during ALU_WAIT with a byte stuck in the queue
        hold_busy = 1; wait_cycles(2);
        t0 = n_tx;
        send_byte(8'hBB); send_byte(8'h05);
        wait_cycles(10);
        alu_hang = 1;
        a0 = n_alu_en;
        send_byte(8'hDD); send_byte(8'h00);
        wait_alu(a0, "rst_alu_start");
        wait_cycles(3);
        check("alu_wait_clk_en", 32'(CLK_EN), 1);
        @(negedge CLK); RST = 1'b1;
        #1;
        check_outputs_zero("midrst");
        hold_busy = 0; alu_hang = 0;
        wait_cycles(3);
        @(negedge CLK); RST = 1'b0;
        wait_cycles(20);
        check("reset_drops_queue", 32'(n_tx - t0), 0);
        frame_rd(8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
